// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared types and constants for the double-buffered frame-buffer
//            write-port controller.
// Contents : fb_state_t - controller sequencing states
//            FB_NPIX    - pixels per frame at the default 320x180 geometry
//            FB_ADDR_W  - default frame-buffer address width
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int FB_NPIX   = 320 * 180;
  localparam int FB_ADDR_W = 16;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_double_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_double_buffer_ctrl_if
// Purpose  : Bundles the renderer pixel handshake, frame timing strobes and
//            the shared port-A write bus of the two frame buffers.
// Modports : slave  - controller view (timing/pixels in, write bus out)
//            master - environment view (drives timing/pixels, observes bus)
// Signals  : frame_end_in, px_valid_in, px_addr_in, px_color_in,
//            render_done_in, px_ready_out, render_start_out, we_out,
//            addr_out, data_out, display_sel_out, swap_out,
//            missed_frames_out
// Revision : 1.0 - initial release
// ============================================================================
interface fb_double_buffer_ctrl_if #(
  parameter int ADDR_W  = fb_pkg::FB_ADDR_W,
  parameter int COLOR_W = 16
);

  logic               frame_end_in;
  logic               px_valid_in;
  logic [ADDR_W-1:0]  px_addr_in;
  logic [COLOR_W-1:0] px_color_in;
  logic               px_ready_out;
  logic               render_done_in;
  logic               render_start_out;
  logic [1:0]         we_out;
  logic [ADDR_W-1:0]  addr_out;
  logic [COLOR_W-1:0] data_out;
  logic               display_sel_out;
  logic               swap_out;
  logic [7:0]         missed_frames_out;

  modport slave (
    input  frame_end_in, px_valid_in, px_addr_in, px_color_in, render_done_in,
    output px_ready_out, render_start_out, we_out, addr_out, data_out,
           display_sel_out, swap_out, missed_frames_out
  );

  modport master (
    output frame_end_in, px_valid_in, px_addr_in, px_color_in, render_done_in,
    input  px_ready_out, render_start_out, we_out, addr_out, data_out,
           display_sel_out, swap_out, missed_frames_out
  );

endinterface
`default_nettype wire

// File: rtl/fb_double_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_double_buffer_ctrl
// Purpose  : Sequencer and port-A write arbiter for two frame buffers. Clears
//            the draw buffer before each scene, forwards renderer pixels into
//            it, and swaps display/draw buffers on a frame boundary once the
//            renderer reports the scene complete.
// Ports    : clk_in  - system clock, rising edge
//            rst_in  - synchronous active-high reset
//            bus     - fb_double_buffer_ctrl_if.slave (pixel handshake,
//                      frame/render strobes, registered write bus, status)
// Revision : 1.0 - initial release
// ============================================================================
module fb_double_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int                 FB_WIDTH    = 320,
  parameter int                 FB_HEIGHT   = 180,
  parameter int                 ADDR_W      = FB_ADDR_W,
  parameter int                 COLOR_W     = 16,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  wire logic                   clk_in,
  input  wire logic                   rst_in,
  fb_double_buffer_ctrl_if.slave      bus
);

  localparam int                NPIX      = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  // One bit wider than the address so NPIX itself is representable.
  localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);

  fb_state_t          state_q,     state_d;
  logic [ADDR_W-1:0]  clear_cnt_q, clear_cnt_d;
  logic               disp_sel_q,  disp_sel_d;
  logic               swap_q,      swap_d;
  logic               start_q,     start_d;
  logic [7:0]         missed_q,    missed_d;
  logic [1:0]         we_q,        we_d;
  logic [ADDR_W-1:0]  addr_q,      addr_d;
  logic [COLOR_W-1:0] data_q,      data_d;

  // Write-enable pattern for the buffer not being scanned out. Because the
  // display select only changes on the swap, this always targets the draw
  // buffer and can never hit both buffers at once.
  logic [1:0] w_draw_we;
  assign w_draw_we = disp_sel_q ? 2'b01 : 2'b10;

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    disp_sel_d  = disp_sel_q;
    swap_d      = 1'b0;
    start_d     = 1'b0;
    missed_d    = missed_q;
    we_d        = 2'b00;
    addr_d      = addr_q;
    data_d      = data_q;

    // Any frame boundary outside WAIT_SWAP is a frame shown without a swap.
    if (bus.frame_end_in && (state_q != WAIT_SWAP) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    unique case (state_q)
      CLEAR: begin
        we_d        = w_draw_we;
        addr_d      = clear_cnt_q;
        data_d      = CLEAR_COLOR;
        clear_cnt_d = clear_cnt_q + ADDR_W'(1);
        if (clear_cnt_q == LAST_ADDR) begin
          state_d = DRAW;
          start_d = 1'b1;
        end
      end
      DRAW: begin
        // Out-of-range pixels are still accepted, just never written.
        if (bus.px_valid_in && ({1'b0, bus.px_addr_in} < NPIX_EXT)) begin
          we_d   = w_draw_we;
          addr_d = bus.px_addr_in;
          data_d = bus.px_color_in;
        end
        if (bus.render_done_in) begin
          state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (bus.frame_end_in) begin
          state_d     = CLEAR;
          clear_cnt_d = '0;
          disp_sel_d  = ~disp_sel_q;
          swap_d      = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= CLEAR;
      clear_cnt_q <= '0;
      disp_sel_q  <= 1'b0;
      swap_q      <= 1'b0;
      start_q     <= 1'b0;
      missed_q    <= 8'd0;
      we_q        <= 2'b00;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      disp_sel_q  <= disp_sel_d;
      swap_q      <= swap_d;
      start_q     <= start_d;
      missed_q    <= missed_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Ready depends on state alone so the renderer sees no combinational path
  // from its own valid.
  assign bus.px_ready_out      = (state_q == DRAW);
  assign bus.render_start_out  = start_q;
  assign bus.we_out            = we_q;
  assign bus.addr_out          = addr_q;
  assign bus.data_out          = data_q;
  assign bus.display_sel_out   = disp_sel_q;
  assign bus.swap_out          = swap_q;
  assign bus.missed_frames_out = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_double_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_double_buffer_ctrl
// Purpose  : Self-checking bench for fb_double_buffer_ctrl using a reduced
//            20x10 frame. Stimulus updates a timeline-based reference model
//            and queues expected writes, swaps and render starts; a negedge
//            monitor pops and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_double_buffer_ctrl;

  localparam int W    = 20;
  localparam int H    = 10;
  localparam int NPIX = W * H;
  localparam int AW   = 16;
  localparam int CW   = 16;
  localparam logic [CW-1:0] CLR = 16'h0000;

  typedef struct packed {
    logic [1:0]    we;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_double_buffer_ctrl_if #(.ADDR_W(AW), .COLOR_W(CW)) bus ();

  fb_double_buffer_ctrl #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .ADDR_W     (AW),
    .COLOR_W    (CW),
    .CLEAR_COLOR(CLR)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues.
  wr_t wr_q[$];
  int  swap_q[$];
  int  start_q[$];

  // Reference model: timeline of the current scene.
  int  draw_start = 0;   // first period in which pixels are accepted
  bit  done       = 1'b0;
  bit  disp       = 1'b0;
  int  missed     = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (period %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void report_fail(string name, logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, nothing expected (period %0d)", name, act, cyc);
  endfunction

  function automatic logic [1:0] draw_we();
    return disp ? 2'b01 : 2'b10;
  endfunction

  function automatic void push_clear();
    wr_t w;
    for (int k = 0; k < NPIX; k++) begin
      w.we   = draw_we();
      w.addr = AW'(k);
      w.data = CLR;
      wr_q.push_back(w);
    end
  endfunction

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (bus.we_out != 2'b00) begin
      got = '{we: bus.we_out, addr: bus.addr_out, data: bus.data_out};
      if (wr_q.size() == 0) begin
        report_fail("write_unexpected", 64'(got));
      end else begin
        exp = wr_q.pop_front();
        check("write", 64'(got), 64'(exp));
      end
    end
    if (bus.swap_out === 1'b1) begin
      if (swap_q.size() == 0) report_fail("swap_unexpected", 64'(cyc));
      else check("swap_period", 64'(cyc), 64'(swap_q.pop_front()));
    end else if (swap_q.size() != 0 && swap_q[0] <= cyc) begin
      check("swap_missing", 64'(cyc), 64'(swap_q.pop_front()));
    end
    if (bus.render_start_out === 1'b1) begin
      if (start_q.size() == 0) report_fail("start_unexpected", 64'(cyc));
      else check("start_period", 64'(cyc), 64'(start_q.pop_front()));
    end else if (start_q.size() != 0 && start_q[0] <= cyc) begin
      check("start_missing", 64'(cyc), 64'(start_q.pop_front()));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One period of stimulus; the model decides the effect of the inputs
  // sampled at the end of this period.
  task automatic tick(input bit v, input logic [AW-1:0] a, input logic [CW-1:0] c,
                      input bit rd, input bit fe);
    int  p        = cyc;
    bit  clearing = (p < draw_start);
    bit  drawing  = !clearing && !done;
    wr_t w;
    check("display_sel", 64'(bus.display_sel_out), 64'(disp));
    check("missed_frames", 64'(bus.missed_frames_out), 64'(missed));
    check("px_ready", 64'(bus.px_ready_out), 64'(drawing));
    bus.px_valid_in    = v;
    bus.px_addr_in     = a;
    bus.px_color_in    = c;
    bus.render_done_in = rd;
    bus.frame_end_in   = fe;
    if (drawing) begin
      if (v && (int'(a) < NPIX)) begin
        w.we   = draw_we();
        w.addr = a;
        w.data = c;
        wr_q.push_back(w);
      end
      if (rd) done = 1'b1;
    end
    if (fe) begin
      if (!clearing && !drawing) begin
        disp       = ~disp;
        done       = 1'b0;
        draw_start = p + 1 + NPIX;
        swap_q.push_back(p + 1);
        start_q.push_back(draw_start);
        push_clear();
      end else if (missed < 255) begin
        missed++;
      end
    end
    next();
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_tick(input int rd_odds, input int fe_odds);
    tick(1'($urandom_range(0, 1)),
         AW'($urandom_range(0, NPIX + 30)),
         CW'($urandom),
         (rd_odds > 0) && ($urandom_range(1, rd_odds) == 1),
         (fe_odds > 0) && ($urandom_range(1, fe_odds) == 1));
  endtask

  task automatic do_reset(input int n);
    rst                = 1'b1;
    bus.px_valid_in    = 1'b0;
    bus.px_addr_in     = '0;
    bus.px_color_in    = '0;
    bus.render_done_in = 1'b0;
    bus.frame_end_in   = 1'b0;
    next();
    wr_q.delete();
    swap_q.delete();
    start_q.delete();
    check("we_after_reset", 64'(bus.we_out), 64'd0);
    repeat (n - 1) next();
    rst = 1'b0;
    check("swap_in_reset", 64'(bus.swap_out), 64'd0);
    check("start_in_reset", 64'(bus.render_start_out), 64'd0);
    check("addr_in_reset", 64'(bus.addr_out), 64'd0);
    check("data_in_reset", 64'(bus.data_out), 64'd0);
    disp       = 1'b0;
    missed     = 0;
    done       = 1'b0;
    draw_start = cyc + NPIX;
    start_q.push_back(draw_start);
    push_clear();
  endtask

  initial begin
    bus.px_valid_in    = 1'b0;
    bus.px_addr_in     = '0;
    bus.px_color_in    = '0;
    bus.render_done_in = 1'b0;
    bus.frame_end_in   = 1'b0;

    // Reset, then an idle full clear of buffer 1.
    do_reset(3);
    repeat (NPIX + 2) idle();

    // In-range and out-of-range pixel, then random drawing.
    tick(1'b1, AW'(100), 16'hF800, 1'b0, 1'b0);
    tick(1'b1, AW'(NPIX), 16'hFFFF, 1'b0, 1'b0);
    repeat (40) rand_tick(0, 0);

    // Render done, frame end ten periods later -> swap, clear of buffer 0.
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (9) idle();
    tick(1'b0, '0, '0, 1'b0, 1'b1);

    // Three missed frames during the clear.
    repeat (3) begin
      repeat (7) idle();
      tick(1'b0, '0, '0, 1'b0, 1'b1);
    end
    repeat (NPIX) idle();

    // Render done and frame end together: miss now, swap on next frame end.
    tick(1'b1, AW'(5), 16'h1234, 1'b1, 1'b1);
    repeat (4) idle();
    tick(1'b0, '0, '0, 1'b0, 1'b1);

    // Frame end every period for 300 periods: counter saturates.
    repeat (300) tick(1'b0, '0, '0, 1'b0, 1'b1);
    check("missed_saturated", 64'(bus.missed_frames_out), 64'd255);

    // Swap, then reset halfway through the clear.
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (NPIX / 2) idle();
    do_reset(1);

    // Randomised operation across several scenes.
    repeat (1500) rand_tick(30, 20);

    // Drain any clear still in flight.
    repeat (NPIX + 5) idle();
    check("writes_left", 64'(wr_q.size()), 64'd0);
    check("swaps_left", 64'(swap_q.size()), 64'd0);
    check("starts_left", 64'(start_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
